// File: rtl/uart_pkg.sv
// Shared UART types, constants and the bit-vote helper.
// Latency: none (types and a combinational function only).
// Backpressure: none.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int UART_DATA_BITS = 8;

    // 2-of-3 majority used to resolve each oversampled bit.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a selectable reset value.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; samples every cycle.
// Ports: clk, rst_n (async active-low), d (async input), q (synchronized output).
module bit_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rx_engine.sv
// UART 8N1 receive engine: oversampled start detect, 3-sample majority per bit, writes good bytes to the RX FIFO.
// Latency: write strobe 9*OSR + OSR/2 + 1 ticks after the start-detect tick, plus 1 clk (and 2 clk of line sync).
// Backpressure: none on the line; a good byte arriving while the FIFO is full is dropped and flagged as overrun.
// Ports: clk_i, reset_n_i (async active-low), osr_tick_i (oversample strobe), rx_en_i (start-detect enable),
//        rx_i (serial line), rx_fifo_full_i -> rx_fifo_wen_o / rx_fifo_data_o (FIFO write side),
//        rx_busy_o (not IDLE), frame_err_o / overrun_err_o (single-cycle error pulses).
module rx_engine
    import uart_pkg::*;
#(
    parameter int OSR = 16
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       osr_tick_i,
    input  logic       rx_en_i,
    input  logic       rx_i,
    input  logic       rx_fifo_full_i,
    output logic       rx_fifo_wen_o,
    output logic [7:0] rx_fifo_data_o,
    output logic       rx_busy_o,
    output logic       frame_err_o,
    output logic       overrun_err_o
);

    localparam int CW = $clog2(OSR);
    localparam logic [CW-1:0] VOTE_A   = CW'(OSR / 2 - 1);
    localparam logic [CW-1:0] VOTE_B   = CW'(OSR / 2);
    localparam logic [CW-1:0] VOTE_C   = CW'(OSR / 2 + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(OSR - 1);
    localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

    rx_state_t                     state;
    logic [CW-1:0]                 osr_cnt;
    logic [2:0]                    bit_cnt;
    logic [UART_DATA_BITS-1:0]     shift_r;
    logic                          rx_s;
    logic                          prev_s;
    logic                          samp_a;
    logic                          samp_b;
    logic                          vote;
    logic                          at_vote;

    bit_sync #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk_i),
        .rst_n (reset_n_i),
        .d     (rx_i),
        .q     (rx_s)
    );

    // Third sample is taken live on the resolving tick.
    assign vote      = maj3(samp_a, samp_b, rx_s);
    assign at_vote   = (osr_cnt == VOTE_C);
    assign rx_busy_o = (state != IDLE);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state          <= IDLE;
            osr_cnt        <= '0;
            bit_cnt        <= '0;
            shift_r        <= '0;
            prev_s         <= 1'b1;
            samp_a         <= 1'b1;
            samp_b         <= 1'b1;
            rx_fifo_wen_o  <= 1'b0;
            rx_fifo_data_o <= '0;
            frame_err_o    <= 1'b0;
            overrun_err_o  <= 1'b0;
        end else begin
            rx_fifo_wen_o <= 1'b0;
            frame_err_o   <= 1'b0;
            overrun_err_o <= 1'b0;

            if (osr_tick_i) begin
                prev_s <= rx_s;
                if (state != IDLE) begin
                    osr_cnt <= (osr_cnt == LAST_CNT) ? '0 : osr_cnt + 1'b1;
                end
                if (osr_cnt == VOTE_A) samp_a <= rx_s;
                if (osr_cnt == VOTE_B) samp_b <= rx_s;

                case (state)
                    IDLE: begin
                        // Detection tick is count 0 of the start window, so the
                        // first tick spent in START already sees count 1.
                        if (rx_en_i && prev_s && !rx_s) begin
                            state   <= START;
                            osr_cnt <= CW'(1);
                        end
                    end
                    START: begin
                        if (at_vote && vote) begin
                            state <= IDLE;       // glitch, not a real start bit
                        end else if (osr_cnt == LAST_CNT) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        if (at_vote) shift_r <= {vote, shift_r[UART_DATA_BITS-1:1]};
                        if (osr_cnt == LAST_CNT) begin
                            if (bit_cnt == LAST_BIT) state <= STOP;
                            else                     bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        // Leave mid stop bit so a following start edge is not missed.
                        if (at_vote) begin
                            state <= IDLE;
                            if (!vote) begin
                                frame_err_o <= 1'b1;
                                prev_s      <= 1'b0;   // line must go high before the next start
                            end else if (rx_fifo_full_i) begin
                                overrun_err_o <= 1'b1;
                            end else begin
                                rx_fifo_wen_o  <= 1'b1;
                                rx_fifo_data_o <= shift_r;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_engine.sv
module tb_rx_engine;

    localparam int OSR = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       osr_tick = 1'b0;
    logic       rx_en = 1'b0;
    logic       rx = 1'b1;
    logic       full = 1'b0;
    logic       wen;
    logic [7:0] data;
    logic       busy;
    logic       ferr;
    logic       ovr;

    int checks = 0;
    int errors = 0;
    int tick_cnt = 0;
    int wr_cnt = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int busy_fall = 0;
    int last_wr_tick = 0;
    logic prev_busy = 1'b0;
    logic mid_busy;
    logic [7:0] exp_q[$];
    event tick_ev;

    rx_engine #(.OSR(OSR)) dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .osr_tick_i     (osr_tick),
        .rx_en_i        (rx_en),
        .rx_i           (rx),
        .rx_fifo_full_i (full),
        .rx_fifo_wen_o  (wen),
        .rx_fifo_data_o (data),
        .rx_busy_o      (busy),
        .frame_err_o    (ferr),
        .overrun_err_o  (ovr)
    );

    always #5 clk = ~clk;

    // One-cycle oversample strobe every 11 clocks.
    initial begin
        forever begin
            repeat (10) @(negedge clk);
            osr_tick = 1'b1;
            @(negedge clk);
            osr_tick = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (osr_tick) begin
            tick_cnt <= tick_cnt + 1;
            -> tick_ev;
        end
    end

    // Scoreboard: every write is popped against the expected queue.
    always @(negedge clk) begin
        if (wen) begin
            wr_cnt++;
            last_wr_tick = tick_cnt;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got %h expected none", data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (data !== e) begin
                    errors++;
                    $display("FAIL write_data got %h expected %h", data, e);
                end
            end
        end
        if (ferr) ferr_cnt++;
        if (ovr)  ovr_cnt++;
        if (prev_busy && !busy) busy_fall++;
        prev_busy = busy;
    end

    task automatic wait_ticks(input int n);
        repeat (n) @(tick_ev);
        #1;
    endtask

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        wait_ticks(n);
    endtask

    // glitch_bit >= 0 puts a one-tick low pulse at the centre tick of that data bit.
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int glitch_bit);
        drive_bit(1'b0, OSR);
        mid_busy = busy;
        for (int b = 0; b < 8; b++) begin
            if (b == glitch_bit) begin
                drive_bit(1'b1, OSR / 2);
                drive_bit(1'b0, 1);
                drive_bit(1'b1, OSR / 2 - 1);
            end else begin
                drive_bit(d[b], OSR);
            end
        end
        drive_bit(stop_v, OSR);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (wen !== 1'b0)   begin errors++; $display("FAIL reset_wen got %b expected 0", wen); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %h expected 00", data); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
        checks++; if (ferr !== 1'b0 || ovr !== 1'b0) begin errors++; $display("FAIL reset_err got %b%b expected 00", ferr, ovr); end
        reset_n = 1'b1;
        rx_en = 1'b1;
        wait_ticks(4);
    endtask

    task automatic test_single;
        int w0, f0, o0, t0;
        w0 = wr_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_pre got %b expected 0", busy); end
        exp_q.push_back(8'hA5);
        t0 = tick_cnt;
        send_frame(8'hA5, 1'b1, -1);
        checks++; if (mid_busy !== 1'b1) begin errors++; $display("FAIL single_busy_mid got %b expected 1", mid_busy); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_post got %b expected 0", busy); end
        checks++; if (wr_cnt != w0 + 1) begin errors++; $display("FAIL single_writes got %0d expected %0d", wr_cnt - w0, 1); end
        checks++; if (last_wr_tick != t0 + 9 * OSR + OSR / 2 + 2) begin
            errors++; $display("FAIL single_latency got %0d expected %0d", last_wr_tick - t0, 9 * OSR + OSR / 2 + 2);
        end
        checks++; if (ferr_cnt != f0 || ovr_cnt != o0) begin errors++; $display("FAIL single_errs got %0d/%0d expected 0/0", ferr_cnt - f0, ovr_cnt - o0); end
    endtask

    task automatic test_back_to_back;
        int w0, b0;
        w0 = wr_cnt; b0 = busy_fall;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        send_frame(8'h55, 1'b1, -1);
        send_frame(8'hAA, 1'b1, -1);
        checks++; if (wr_cnt != w0 + 2) begin errors++; $display("FAIL b2b_writes got %0d expected 2", wr_cnt - w0); end
        checks++; if (busy_fall != b0 + 2) begin errors++; $display("FAIL b2b_busy_falls got %0d expected 2", busy_fall - b0); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_pending got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_glitch;
        int w0, f0, o0;
        w0 = wr_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
        drive_bit(1'b0, 4);
        drive_bit(1'b1, OSR + 4);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got %b expected 0", busy); end
        checks++; if (wr_cnt != w0 || ferr_cnt != f0 || ovr_cnt != o0) begin
            errors++; $display("FAIL glitch_outputs got w%0d f%0d o%0d expected 0 0 0", wr_cnt - w0, ferr_cnt - f0, ovr_cnt - o0);
        end
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, -1);
        checks++; if (wr_cnt != w0 + 1) begin errors++; $display("FAIL glitch_followup got %0d expected 1", wr_cnt - w0); end
    endtask

    task automatic test_frame_err;
        int w0, f0;
        w0 = wr_cnt; f0 = ferr_cnt;
        send_frame(8'h81, 1'b0, -1);
        checks++; if (ferr_cnt != f0 + 1) begin errors++; $display("FAIL ferr_pulse got %0d expected 1", ferr_cnt - f0); end
        checks++; if (wr_cnt != w0) begin errors++; $display("FAIL ferr_write got %0d expected 0", wr_cnt - w0); end
        drive_bit(1'b0, 3 * OSR);
        checks++; if (busy !== 1'b0 || ferr_cnt != f0 + 1) begin
            errors++; $display("FAIL break_retrigger got busy %b ferr %0d expected 0 1", busy, ferr_cnt - f0);
        end
        drive_bit(1'b1, OSR);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, -1);
        checks++; if (wr_cnt != w0 + 1) begin errors++; $display("FAIL ferr_recover got %0d expected 1", wr_cnt - w0); end
    endtask

    task automatic test_overrun;
        int w0, f0, o0;
        w0 = wr_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
        full = 1'b1;
        send_frame(8'h12, 1'b1, -1);
        checks++; if (ovr_cnt != o0 + 1) begin errors++; $display("FAIL overrun_pulse got %0d expected 1", ovr_cnt - o0); end
        checks++; if (wr_cnt != w0) begin errors++; $display("FAIL overrun_write got %0d expected 0", wr_cnt - w0); end
        // Full and bad stop bit together: only the framing error is reported.
        send_frame(8'h34, 1'b0, -1);
        full = 1'b0;
        drive_bit(1'b1, OSR);
        checks++; if (ferr_cnt != f0 + 1 || ovr_cnt != o0 + 1) begin
            errors++; $display("FAIL full_and_ferr got f%0d o%0d expected 1 1", ferr_cnt - f0, ovr_cnt - o0);
        end
    endtask

    task automatic test_majority;
        int w0;
        w0 = wr_cnt;
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 1'b1, 3);
        checks++; if (wr_cnt != w0 + 1) begin errors++; $display("FAIL majority_writes got %0d expected 1", wr_cnt - w0); end
    endtask

    task automatic test_disable;
        int w0;
        w0 = wr_cnt;
        rx_en = 1'b0;
        send_frame(8'h99, 1'b1, -1);
        rx_en = 1'b1;
        checks++; if (wr_cnt != w0 || busy !== 1'b0) begin
            errors++; $display("FAIL disable got writes %0d busy %b expected 0 0", wr_cnt - w0, busy);
        end
    endtask

    task automatic test_reset_mid;
        int w0;
        drive_bit(1'b0, OSR);
        drive_bit(1'b1, OSR);          // C3 bit0
        drive_bit(1'b1, OSR);          // bit1
        drive_bit(1'b0, OSR);          // bit2
        drive_bit(1'b0, 5);            // part of bit3
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_pre got %b expected 1", busy); end
        #3;
        reset_n = 1'b0;
        #2;
        checks++; if (busy !== 1'b0 || wen !== 1'b0 || ferr !== 1'b0 || ovr !== 1'b0) begin
            errors++; $display("FAIL rstmid_async got busy %b wen %b ferr %b ovr %b expected 0000", busy, wen, ferr, ovr);
        end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h expected 00", data); end
        repeat (3) @(negedge clk);
        rx = 1'b1;
        reset_n = 1'b1;
        wait_ticks(2 * OSR);
        w0 = wr_cnt;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, -1);
        checks++; if (wr_cnt != w0 + 1 || exp_q.size() != 0) begin
            errors++; $display("FAIL rstmid_recover got writes %0d pending %0d expected 1 0", wr_cnt - w0, exp_q.size());
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_glitch;
        test_frame_err;
        test_overrun;
        test_majority;
        test_disable;
        test_reset_mid;
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL final_pending got %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
